ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Four-requester round-robin arbiter that shares one datapath resource, such as the register-file write port or the data-memory port, between up to four masters. Rotating priority is held as a 4-bit active-low one-hot ring pointer, the same encoding as the team's ring counters. Grants are also active-low one-hot. A grant is held until its owner signals `done`, or optionally until a timeout. The block sits between the requesting units and the resource mux, and its `grant_n` drives the mux selects directly.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum cycles a grant may be held, used only with the timeout feature; legal range 1..255.
- `CNT_W`, default 8: width of the hold counter; must satisfy `HOLD_MAX` < 2^`CNT_W`.

Ports:
- `clock`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `req`  in  4  request lines; bit i is high while requester i wants the resource.
- `done`  in  4  release strobe; bit i is meaningful only while requester i owns the grant.
- `grant_n`  out  4  active-low one-hot grant; 1111 means no owner.
- `owner`  out  2  binary index of the current owner; valid only while `busy`=1.
- `busy`  out  1  high while a grant is active.
- `ptr_n`  out  4  active-low one-hot priority pointer; the zero bit marks the highest-priority requester.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- FSM with two states, IDLE and GRANT. All outputs are registered.
- Reset values: state=IDLE, `grant_n`=1111, `ptr_n`=1110 (requester 0 highest), `owner`=0, `busy`=0, `timeout`=0, hold counter=0.
- IDLE, `req`=0000: stay in IDLE; all outputs hold.
- IDLE, `req`≠0000: search ascending from the pointer index, mod 4. The first set bit i wins.
  - At the clock edge: `grant_n` gets bit i cleared, `owner`=i, `busy`=1, state → GRANT.
  - `ptr_n` is unchanged on a grant.
- GRANT, `done[owner]`=1 at an edge:
  - `grant_n`=1111, `busy`=0, state → IDLE.
  - `ptr_n` becomes the one-hot-low encoding of (owner+1) mod 4.
- GRANT, other conditions:
  - `done` bits of non-owners are ignored.
  - The owner dropping `req` without `done` does not release the grant.
  - New requests wait.
- Fairness: under continuous requests from all four requesters, grants go 0,1,2,3,0,… with no starvation.
- Reset asserted in any state, including mid-grant, forces the reset values at that edge. Reset overrides `done` and timeout.

## Timing
- Grant latency: `req` high before edge k (state IDLE) → `grant_n` low after edge k. One cycle.
- Release: `done[owner]` high before edge k → `grant_n`=1111 after edge k.
- Turnaround: the earliest next grant appears after edge k+1. There is always at least one idle cycle between owners.
- Simultaneous `done[owner]` and timeout expiry at the same edge: treated as a normal release; `timeout` stays 0.
- `owner` holds its last value in IDLE.

## Configuration
- Macro: `RING_RR_ARBITER_TIMEOUT_EN`.
- Defined:
  - A `CNT_W`-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals `HOLD_MAX` and no `done[owner]` is present, the grant is released exactly as for `done`, and the pointer advances.
  - `timeout`=1 for that one cycle.
- Undefined:
  - No counter is built; `timeout` is tied to 0; grants are held indefinitely.
  - The port list is identical in both builds.

## Structure
- Shared package `arb_pkg` holds:
  - `NUM_REQ`=4.
  - The FSM state typedef (IDLE, GRANT).
  - Constants `GRANT_NONE_N`=4'b1111 and `PTR_RESET_N`=4'b1110.
  - Helper functions for index↔active-low one-hot conversion.
- One combinational sub-module, `rr_pick`, is natural:
  - Inputs: `req` and `ptr_n`.
  - Outputs: `win_idx[1:0]` and `win_valid`.
  - The FSM and registers stay in `ring_rr_arbiter`.

## Test plan
- Reset then idle: assert `reset` for 2 cycles with `req`=1111 → `grant_n`=1111, `ptr_n`=1110, `busy`=0 during reset; one cycle after reset releases, `grant_n`=1110, `owner`=0.
- Rotation: hold `req`=1111 and pulse `done[owner]` one cycle after each grant → owners 0,1,2,3,0; `ptr_n` sequence after each release is 1101, 1011, 0111, 1110.
- Pointer skip: `ptr_n`=1011 (pointer at 2) with `req`=0010 → owner=1, `grant_n`=1101; after `done[1]`, `ptr_n`=1011.
- Ignored inputs: owner=2; drive `done`=1011 (owner's bit clear) and `req`=0000 for 5 cycles → `grant_n` stays 1011 and `busy` stays 1.
- Mid-grant reset: owner=3; assert `reset` for one edge → `grant_n`=1111, `ptr_n`=1110, state IDLE at that edge.
- Timeout (macro defined, `HOLD_MAX`=4): grant to 0 with no `done` → release after 4 GRANT cycles with a one-cycle `timeout` pulse and `ptr_n`=1101; the same stimulus with the macro undefined → grant held and `timeout`=0 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, constants and one-hot helpers for the ring round-robin arbiter.
// Active-low one-hot is used for both the priority pointer and the grant bus.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] GRANT_NONE_N = 4'b1111;
    localparam logic [3:0] PTR_RESET_N  = 4'b1110;

    function automatic logic [3:0] idx_to_onehot_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [1:0] onehot_n_to_idx(input logic [3:0] v_n);
        logic [1:0] idx;
        case (1'b1)
            !v_n[0]: idx = 2'd0;
            !v_n[1]: idx = 2'd1;
            !v_n[2]: idx = 2'd2;
            !v_n[3]: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: first set request at or after the pointer,
// scanning upward modulo four.
module rr_pick
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] ptr_n,
    output logic [1:0] win_idx,
    output logic       win_valid
);

    logic [1:0] base;
    logic [1:0] cand;

    always_comb begin
        win_idx   = 2'd0;
        win_valid = 1'b0;
        base      = onehot_n_to_idx(ptr_n);
        cand      = 2'd0;
        // Scan farthest-first so the nearest hit overwrites and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = base + 2'(k);
            if (req[cand]) begin
                win_idx   = cand;
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Four-way round-robin arbiter with held grants and active-low one-hot outputs.
// Optional forced release after HOLD_MAX cycles: RING_RR_ARBITER_TIMEOUT_EN.
module ring_rr_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant_n,
    output logic [1:0] owner,
    output logic       busy,
    output logic [3:0] ptr_n,
    output logic       timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX >= (2 ** CNT_W)) begin : g_param_chk
        $error("ring_rr_arbiter: HOLD_MAX out of range for CNT_W");
    end

    state_t     state;
    state_t     state_nxt;
    logic [3:0] grant_n_nxt;
    logic [3:0] ptr_n_nxt;
    logic [1:0] owner_nxt;
    logic       busy_nxt;
    logic       timeout_nxt;

    logic [1:0] win_idx;
    logic       win_valid;
    logic       rel_done;
    logic       expire;

    rr_pick u_pick (
        .req       (req),
        .ptr_n     (ptr_n),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign rel_done = done[owner];

`ifdef RING_RR_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // cnt_inc is the number of GRANT cycles including the current one.
    assign cnt_inc = cnt + CNT_W'(1);
    assign expire  = (state == GRANT) && !rel_done
                     && (cnt_inc == CNT_W'(HOLD_MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == GRANT) begin
            cnt <= cnt_inc;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_n_nxt = grant_n;
        ptr_n_nxt   = ptr_n;
        owner_nxt   = owner;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_n_nxt = idx_to_onehot_n(win_idx);
                    owner_nxt   = win_idx;
                    busy_nxt    = 1'b1;
                end
            end
            GRANT: begin
                // A real done takes precedence, so expire already excludes it.
                if (rel_done || expire) begin
                    grant_n_nxt = GRANT_NONE_N;
                    busy_nxt    = 1'b0;
                    ptr_n_nxt   = idx_to_onehot_n(owner + 2'd1);
                    timeout_nxt = expire;
                end
            end
            default: begin
                grant_n_nxt = GRANT_NONE_N;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_n <= GRANT_NONE_N;
            ptr_n   <= PTR_RESET_N;
            owner   <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            grant_n <= grant_n_nxt;
            ptr_n   <= ptr_n_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter; HOLD_MAX=4 so the timeout scenario is short.
// Timeout checks follow RING_RR_ARBITER_TIMEOUT_EN as seen by this compile.
module tb_ring_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant_n;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] ptr_n;
    logic       timeout;

    int checks;
    int errors;

    ring_rr_arbiter #(
        .HOLD_MAX (4),
        .CNT_W    (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant_n (grant_n),
        .owner   (owner),
        .busy    (busy),
        .ptr_n   (ptr_n),
        .timeout (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        done  = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk4("reset grant_n", grant_n, 4'b1111);
            chk4("reset ptr_n", ptr_n, 4'b1110);
            chk4("reset busy", {3'b0, busy}, 4'b0000);
            chk4("reset timeout", {3'b0, timeout}, 4'b0000);
        end
        reset = 1'b0;
        tick();
        chk4("first grant_n", grant_n, 4'b1110);
        chk4("first owner", {2'b0, owner}, 4'd0);
        chk4("first busy", {3'b0, busy}, 4'b0001);
        chk4("first ptr_n", ptr_n, 4'b1110);
    endtask

    task automatic test_rotation();
        logic [3:0] exp_ptr [4];
        logic [3:0] exp_gnt [4];
        exp_ptr = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_gnt = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            done = 4'b0001 << i;
            tick();
            chk4("rot release grant_n", grant_n, 4'b1111);
            chk4("rot release ptr_n", ptr_n, exp_ptr[i]);
            chk4("rot release busy", {3'b0, busy}, 4'b0000);
            chk4("rot release timeout", {3'b0, timeout}, 4'b0000);
            done = 4'b0000;
            tick();
            chk4("rot grant_n", grant_n, exp_gnt[i]);
            chk4("rot owner", {2'b0, owner}, 4'((i + 1) % 4));
        end
    endtask

    task automatic test_pointer_skip();
        req  = 4'b0010;
        done = 4'b0001;
        tick();
        chk4("skip prep ptr_n", ptr_n, 4'b1101);
        done = 4'b0000;
        tick();
        done = 4'b0010;
        tick();
        chk4("skip prep2 ptr_n", ptr_n, 4'b1011);
        done = 4'b0000;
        tick();
        chk4("skip grant_n", grant_n, 4'b1101);
        chk4("skip owner", {2'b0, owner}, 4'd1);
        done = 4'b0010;
        req  = 4'b0000;
        tick();
        chk4("skip release grant_n", grant_n, 4'b1111);
        chk4("skip release ptr_n", ptr_n, 4'b1011);
        done = 4'b0000;
        tick();
        chk4("idle hold grant_n", grant_n, 4'b1111);
        chk4("idle hold owner", {2'b0, owner}, 4'd1);
    endtask

    task automatic test_ignored_inputs();
        req = 4'b0100;
        tick();
        chk4("ign grant_n", grant_n, 4'b1011);
        chk4("ign owner", {2'b0, owner}, 4'd2);
        req  = 4'b0000;
        done = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk4("ign hold grant_n", grant_n, 4'b1011);
            chk4("ign hold busy", {3'b0, busy}, 4'b0001);
        end
        done = 4'b0100;
        tick();
        chk4("ign release grant_n", grant_n, 4'b1111);
        chk4("ign release ptr_n", ptr_n, 4'b0111);
        done = 4'b0000;
    endtask

    task automatic test_mid_reset();
        req = 4'b1000;
        tick();
        chk4("mrst grant_n", grant_n, 4'b0111);
        chk4("mrst owner", {2'b0, owner}, 4'd3);
        reset = 1'b1;
        done  = 4'b1000;
        tick();
        chk4("mrst reset grant_n", grant_n, 4'b1111);
        chk4("mrst reset ptr_n", ptr_n, 4'b1110);
        chk4("mrst reset busy", {3'b0, busy}, 4'b0000);
        chk4("mrst reset owner", {2'b0, owner}, 4'd0);
        reset = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        tick();
        chk4("mrst idle grant_n", grant_n, 4'b1111);
        chk4("mrst idle busy", {3'b0, busy}, 4'b0000);
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        tick();
        chk4("to grant_n", grant_n, 4'b1110);
        req = 4'b0000;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("to hold grant_n", grant_n, 4'b1110);
            chk4("to hold timeout", {3'b0, timeout}, 4'b0000);
        end
        tick();
        chk4("to expire grant_n", grant_n, 4'b1111);
        chk4("to expire timeout", {3'b0, timeout}, 4'b0001);
        chk4("to expire ptr_n", ptr_n, 4'b1101);
        chk4("to expire busy", {3'b0, busy}, 4'b0000);
        tick();
        chk4("to pulse end", {3'b0, timeout}, 4'b0000);
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            chk4("nto hold grant_n", grant_n, 4'b1110);
            chk4("nto timeout", {3'b0, timeout}, 4'b0000);
        end
        done = 4'b0001;
        tick();
        chk4("nto release grant_n", grant_n, 4'b1111);
        chk4("nto release ptr_n", ptr_n, 4'b1101);
        done = 4'b0000;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        done   = 4'b0000;
        test_reset();
        test_rotation();
        test_pointer_skip();
        test_ignored_inputs();
        test_mid_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
